// File: rtl/seq_mult_8_if.sv
// Operand/result bundle for the shift-and-add multiplier.
// The master drives the request and operands; the slave (the multiplier) returns status and product.
interface seq_mult_8_if #(
  parameter int WIDTH = 8
);
  logic                   start;
  logic [WIDTH-1:0]       a;
  logic [WIDTH-1:0]       b;
  logic                   busy;
  logic                   done;
  logic [2*WIDTH-1:0]     product;

  modport master (output start, output a, output b,
                  input  busy,  input  done, input product);
  modport slave  (input  start, input  a, input  b,
                  output busy,  output done, output product);
endinterface

// File: rtl/seq_mult_8.sv
// Unsigned shift-and-add multiplier: one ripple-carry add and one right shift per clock.
// The product appears WIDTH+2 cycles after an accepted start, with a one-cycle done pulse.
module seq_mult_8 #(
  parameter int WIDTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  seq_mult_8_if.slave bus
);
  localparam int              CW   = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]           state;
  logic [WIDTH-1:0]     m_q;
  logic [WIDTH-1:0]     a_q;
  logic [WIDTH-1:0]     q_q;
  logic                 c_q;
  logic [CW-1:0]        cnt;
  logic                 done_q;
  logic [2*WIDTH-1:0]   product_q;

  logic [WIDTH-1:0]     addend;
  logic [WIDTH-1:0]     sum;
  logic [WIDTH:0]       carry;
  logic                 cout;

  // Ripple-carry adder. C is always zero after each shift, so the carry-in is effectively 0.
  assign addend   = q_q[0] ? m_q : '0;
  assign carry[0] = c_q;

  genvar i;
  generate
    for (i = 0; i < WIDTH; i++) begin : g_rca
      assign sum[i]     = a_q[i] ^ addend[i] ^ carry[i];
      assign carry[i+1] = (a_q[i] & addend[i]) | (carry[i] & (a_q[i] ^ addend[i]));
    end
  endgenerate

  assign cout = carry[WIDTH];

  assign bus.busy    = (state != IDLE);
  assign bus.done    = done_q;
  assign bus.product = product_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      m_q       <= '0;
      a_q       <= '0;
      q_q       <= '0;
      c_q       <= 1'b0;
      cnt       <= '0;
      done_q    <= 1'b0;
      product_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            m_q   <= bus.a;
            q_q   <= bus.b;
            a_q   <= '0;
            c_q   <= 1'b0;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          // Carry-out becomes the new accumulator MSB; S[0] shifts into the multiplier half.
          {c_q, a_q, q_q} <= {cout, sum, q_q} >> 1;
          cnt             <= cnt + 1'b1;
          if (cnt == LAST) state <= DONE;
        end
        DONE: begin
          product_q <= {a_q, q_q};
          done_q    <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_mult_8.sv
// Directed and randomized-operand bench for seq_mult_8: latency, ignored starts, async reset.
module tb_seq_mult_8;
  localparam int WIDTH = 8;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  seq_mult_8_if #(.WIDTH(WIDTH)) bus ();

  seq_mult_8 #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Counts posedges (sampled 1ns after) until done is seen; n = edges waited.
  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!bus.done && n < 40);
  endtask

  // Launch one multiply, check busy/latency/product/done-width.
  task automatic run_mult(input string tag, input logic [7:0] av, input logic [7:0] bv,
                          input logic [15:0] exp);
    int n;
    @(negedge clk);
    bus.a     = av;
    bus.b     = bv;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    chk({tag, "_busy_rise"}, 32'(bus.busy), 32'd1);
    bus.start = 1'b0;
    wait_done(n);
    chk({tag, "_latency"}, 32'(n + 1), 32'(WIDTH + 2));
    chk({tag, "_product"}, 32'(bus.product), 32'(exp));
    chk({tag, "_busy_at_done"}, 32'(bus.busy), 32'd0);
    @(posedge clk);
    #1;
    chk({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
    chk({tag, "_product_hold"}, 32'(bus.product), 32'(exp));
  endtask

  initial begin
    int n;
    int pulses;
    int last_cyc;
    int cyc;
    logic [7:0] ra;
    logic [7:0] rb;
    logic [15:0] rexp;

    checks    = 0;
    failures  = 0;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    rst       = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", 32'(bus.busy), 32'd0);
    chk("reset_done", 32'(bus.done), 32'd0);
    chk("reset_product", 32'(bus.product), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run_mult("m0d_0b", 8'h0D, 8'h0B, 16'h008F);
    run_mult("mff_ff", 8'hFF, 8'hFF, 16'hFE01);
    run_mult("m80_02", 8'h80, 8'h02, 16'h0100);
    run_mult("m00_a5", 8'h00, 8'hA5, 16'h0000);

    // Start and operand changes while busy must be ignored.
    @(negedge clk);
    bus.a = 8'h0D; bus.b = 8'h0B; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    bus.a = 8'hFF; bus.b = 8'hFF; bus.start = 1'b1;
    repeat (3) @(negedge clk);
    bus.start = 1'b0;
    wait_done(n);
    chk("ignore_done_seen", 32'(bus.done), 32'd1);
    chk("ignore_product", 32'(bus.product), 32'h008F);
    pulses = 0;
    repeat (14) begin
      @(posedge clk);
      #1;
      if (bus.done) pulses++;
    end
    chk("ignore_extra_pulses", 32'(pulses), 32'd0);

    // Asynchronous reset in the middle of 0xFF*0xFF.
    @(negedge clk);
    bus.a = 8'hFF; bus.b = 8'hFF; bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("async_rst_busy", 32'(bus.busy), 32'd0);
    chk("async_rst_done", 32'(bus.done), 32'd0);
    chk("async_rst_product", 32'(bus.product), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_mult("m03_05", 8'h03, 8'h05, 16'h000F);

    // Continuous start: new operands are presented in each done cycle.
    @(negedge clk);
    ra = 8'($urandom);
    rb = 8'($urandom);
    rexp = 16'(ra) * 16'(rb);
    bus.a = ra; bus.b = rb; bus.start = 1'b1;
    cyc = 0;
    last_cyc = 0;
    for (int k = 0; k < 1000; k++) begin
      n = 0;
      do begin
        @(posedge clk);
        #1;
        n++;
        cyc++;
      end while (!bus.done && n < 40);
      chk("rand_done_seen", 32'(bus.done), 32'd1);
      chk("rand_product", 32'(bus.product), 32'(rexp));
      if (k > 0) chk("rand_spacing", 32'(cyc - last_cyc), 32'(WIDTH + 2));
      last_cyc = cyc;
      if (!bus.done) break;
      ra = 8'($urandom);
      rb = 8'($urandom);
      rexp = 16'(ra) * 16'(rb);
      bus.a = ra;
      bus.b = rb;
    end
    bus.start = 1'b0;
    repeat (12) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
